// File: rtl/dm_responder.sv
// dm_responder: single-outstanding data-memory responder with power-up clear and fixed response latency
module dm_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam logic [1:0] INIT = 2'd0, IDLE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  localparam logic [3:0] LAT = 4'(LATENCY);
  logic [1:0] state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic we_q, we_d;
  logic [31:2] addr_q, addr_d;
  logic [3:0] be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic err_q, err_d;
  logic [31:0] mem [2**ADDR_W];
  logic [3:0] mem_be;
  logic [ADDR_W-1:0] mem_a, word;
  logic [31:0] mem_wd;
  logic accept, fire, oor;
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr[1:0];
  assign word = addr_q[ADDR_W+1:2];
  assign oor = |addr_q[31:ADDR_W+2];
  assign accept = state_q == IDLE && req_valid;
  assign fire = state_q == WAIT && wcnt_q == 4'd1;
  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
  // next-state, request latching, wait countdown and response capture
  always_comb begin
    case (state_q)
      INIT:    state_d = clr_q == '1 ? IDLE : INIT;
      IDLE:    state_d = req_valid ? WAIT : IDLE;
      WAIT:    state_d = wcnt_q == 4'd1 ? RESP : WAIT;
      default: state_d = resp_ready ? IDLE : RESP;
    endcase
    clr_d = state_q == INIT ? clr_q + 1'b1 : clr_q;
    wcnt_d = accept ? LAT : state_q == WAIT ? wcnt_q - 4'd1 : wcnt_q;
    we_d = accept ? req_we : we_q;
    addr_d = accept ? req_addr[31:2] : addr_q;
    be_d = accept ? req_be : be_q;
    wdata_d = accept ? req_wdata : wdata_q;
    rdata_d = fire ? (we_q || oor ? '0 : mem[word]) : rdata_q;
    err_d = fire ? oor : err_q;
    mem_be = reset ? 4'h0 : state_q == INIT ? 4'hf : fire && we_q && !oor ? be_q : 4'h0;
    mem_a = state_q == INIT ? clr_q : word;
    mem_wd = state_q == INIT ? '0 : wdata_q;
  end
  // control and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      clr_q <= '0;
      wcnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      wcnt_q <= wcnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  // byte-enabled memory write port shared by the clear sweep and stores
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_be[i]) mem[mem_a][8*i+:8] <= mem_wd[8*i+:8];
  end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: random and directed checks of dm_responder against a transaction-level model
module tb_dm_responder;
  localparam int AW = 4, LAT = 2, DEPTH = 16;
  logic clk = 0, reset = 1, req_valid = 0, req_we = 0, resp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_be = 0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  dm_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  logic [31:0] mmem [DEPTH];
  int init_left = 0, due = 0;
  bit pend = 0, have = 0, rst_last = 0, started = 0, l_we = 0, e_err = 0;
  logic [31:0] l_addr = 0, l_wd = 0, e_rdata = 0;
  logic [3:0] l_be = 0;
  logic [AW-1:0] idx;
  always @(posedge clk) begin
    if (reset) begin
      started = 1; rst_last = 1; init_left = DEPTH; pend = 0; have = 0; e_rdata = 0; e_err = 0;
    end else begin
      rst_last = 0;
      if (init_left > 0) begin
        init_left--;
        if (init_left == 0) foreach (mmem[i]) mmem[i] = 0;
      end else if (have) begin
        if (resp_ready) have = 0;
      end else if (pend) begin
        due--;
        if (due == 0) begin
          pend = 0; have = 1; e_rdata = 0;
          e_err = (l_addr >> (AW + 2)) != 0;
          idx = l_addr[AW+1:2];
          if (!e_err) begin
            if (l_we) begin
              for (int b = 0; b < 4; b++) if (l_be[b]) mmem[idx][8*b+:8] = l_wd[8*b+:8];
            end else e_rdata = mmem[idx];
          end
        end
      end else if (req_valid) begin
        l_we = req_we; l_addr = req_addr; l_be = req_be; l_wd = req_wdata; pend = 1; due = LAT;
      end
    end
  end
  always @(negedge clk) if (started) begin
    chk("req_ready", req_ready, init_left == 0 && !pend && !have);
    chk("resp_valid", resp_valid, have);
    if (have || rst_last) begin
      chk("resp_rdata", resp_rdata, e_rdata);
      chk("resp_err", resp_err, e_err);
    end
  end
  task automatic scramble();
    req_we = $urandom; req_addr = $urandom; req_be = $urandom; req_wdata = $urandom;
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) chk("ready_timeout", req_ready, 1);
  endtask
  task automatic do_req(input bit we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output logic err, output int lat);
    int n;
    req_we = we; req_addr = a; req_be = be; req_wdata = wd; req_valid = 1;
    wait_ready(n);
    @(negedge clk);
    req_valid = $urandom_range(0, 1); scramble(); resp_ready = $urandom;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(negedge clk); lat++; scramble(); resp_ready = $urandom;
    end
    chk("resp_arrived", resp_valid, 1);
    rd = resp_rdata; err = resp_err;
    for (int k = 0; k < hold; k++) begin
      resp_ready = 0; @(negedge clk); scramble();
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_err", resp_err, err);
      chk("hold_ready", req_ready, 0);
    end
    resp_ready = 1; @(negedge clk);
    resp_ready = 0; req_valid = 0;
    chk("back_to_idle", req_ready, 1);
  endtask
  task automatic abort_req(input logic [31:0] a, input logic [31:0] wd, input int after);
    int n;
    req_we = 1; req_addr = a; req_be = 4'hf; req_wdata = wd; req_valid = 1; resp_ready = 0;
    wait_ready(n);
    @(negedge clk);
    req_valid = 0;
    repeat (after) @(negedge clk);
    reset = 1; @(negedge clk); reset = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, lat;
    logic [31:0] rd, a;
    logic er;
    reset = 1; @(negedge clk); reset = 0;
    req_valid = 1; req_we = 0; req_addr = 32'h8;
    wait_ready(n);
    chk("init_cycles", n, 16);
    do_req(0, 32'h8, 4'h0, 0, 0, rd, er, lat);
    chk("init_load_rdata", rd, 0); chk("init_load_err", er, 0);
    do_req(1, 32'h4, 4'hf, 32'hDEADBEEF, 0, rd, er, lat);
    chk("store_latency", lat, 2); chk("store_rdata", rd, 0); chk("store_err", er, 0);
    do_req(0, 32'h4, 4'h0, 0, 0, rd, er, lat);
    chk("load_after_store", rd, 32'hDEADBEEF); chk("load_latency", lat, 2);
    do_req(1, 32'h4, 4'b0101, 32'h11223344, 0, rd, er, lat);
    do_req(0, 32'h4, 4'h0, 0, 0, rd, er, lat);
    chk("byte_merge", rd, 32'hDE22BE44);
    do_req(1, 32'h7, 4'h0, 32'hFFFFFFFF, 0, rd, er, lat);
    do_req(0, 32'h5, 4'h0, 0, 0, rd, er, lat);
    chk("be_zero_no_write", rd, 32'hDE22BE44);
    do_req(1, 32'h4000, 4'hf, 32'h12345678, 0, rd, er, lat);
    chk("oor_store_err", er, 1); chk("oor_store_rdata", rd, 0); chk("oor_latency", lat, 2);
    do_req(1, 32'h40, 4'hf, 32'h12345678, 0, rd, er, lat);
    chk("oor_edge_err", er, 1);
    do_req(0, 32'h0, 4'h0, 0, 0, rd, er, lat);
    chk("oor_no_write", rd, 0);
    do_req(0, 32'h80000004, 4'h0, 0, 0, rd, er, lat);
    chk("oor_load_err", er, 1); chk("oor_load_rdata", rd, 0);
    do_req(0, 32'h4, 4'h0, 0, 5, rd, er, lat);
    chk("backpressure_rdata", rd, 32'hDE22BE44);
    abort_req(32'hC, 32'hCAFEF00D, 0);
    wait_ready(n);
    chk("reinit_cycles", n, 16);
    do_req(0, 32'hC, 4'h0, 0, 0, rd, er, lat);
    chk("abort_no_store", rd, 0);
    do_req(0, 32'h4, 4'h0, 0, 0, rd, er, lat);
    chk("reinit_cleared", rd, 0);
    for (int t = 0; t < 300; t++) begin
      a = $urandom_range(0, 7) == 0 ? ($urandom | 32'h40) : ($urandom & 32'h3f);
      if ($urandom_range(0, 24) == 0) abort_req(a, $urandom, $urandom_range(0, 3));
      else do_req($urandom_range(0, 1), a, 4'($urandom), $urandom, $urandom_range(0, 3), rd, er, lat);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
